// File: rtl/hit_judge_pkg.sv
// Shared whack-a-mole definitions: mode and state encodings, widths and
// the saturating add used by every score counter.
package wam_pkg;

  localparam int POS_W = 4;
  localparam int CNT_W = 7;
  localparam logic [POS_W-1:0] NO_POS    = 4'hF;
  localparam logic [CNT_W-1:0] SCORE_SAT = 7'd99;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_TIMED      = 2'd1,
    MODE_DEATH      = 2'd2,
    MODE_NORMAL_ALT = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_RESOLVED = 3'd3,
    ST_OVER     = 3'd4
  } state_e;

  // a + inc clamped to sat; a value already above sat is pulled back to sat
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc,
                                               input logic [CNT_W-1:0] sat);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum > {1'b0, sat}) begin
      sat_add = sat;
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Game-side bus of the scoring engine: light/keypad inputs, game control
// and the score outputs that feed the HEX decoders.
interface hit_judge_if;
  import wam_pkg::*;

  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] max_hits;
  logic             time_up;
  logic             light_valid;
  logic [POS_W-1:0] light_pos;
  logic             key_valid;
  logic [POS_W-1:0] key;
  logic [CNT_W-1:0] points;
  logic [CNT_W-1:0] misses;
  logic [CNT_W-1:0] moles;
  logic [1:0]       lives_left;
  logic             hit_pulse;
  logic             miss_pulse;
  logic             game_over;

  modport master (
    output start, mode, max_hits, time_up, light_valid, light_pos, key_valid, key,
    input  points, misses, moles, lives_left, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  start, mode, max_hits, time_up, light_valid, light_pos, key_valid, key,
    output points, misses, moles, lives_left, hit_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/hit_judge_sat_counter.sv
// 7-bit counter that adds 0, 1 or 2 per cycle and sticks at SAT.
module sat_counter
  import wam_pkg::*;
#(
  parameter logic [CNT_W-1:0] SAT = SCORE_SAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic [1:0]       i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // count register: reset/clear to zero, otherwise saturating accumulate
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 7'd0;
    end else if (i_clr) begin
      r_count <= 7'd0;
    end else begin
      r_count <= sat_add(r_count, i_inc, SAT);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hit_judge.sv
// Whack-a-mole scoring engine: detects mole starts/ends from the light
// controller, judges key strobes as hits or misses and ends the game
// according to the selected mode.
module hit_judge
  import wam_pkg::*;
#(
  parameter int LIVES = 3,
  parameter int SAT   = 99
) (
  input  logic        clk,
  input  logic        reset,
  hit_judge_if.slave  bus
);

  localparam logic [CNT_W-1:0] SAT_C   = SAT[CNT_W-1:0];
  localparam logic [1:0]       LIVES_C = LIVES[1:0];

  state_e           r_state, w_state_next, w_scored;
  logic             r_start_d, r_lv_d, r_hit_pulse, r_miss_pulse, r_game_over;
  logic [POS_W-1:0] r_pos;
  logic [1:0]       r_lives, w_lives_after, w_miss_cnt;
  logic [CNT_W-1:0] w_points, w_misses, w_moles, w_moles_after;
  logic             w_running, w_start_rise, w_mole_start, w_mole_end, w_clr;
  logic             w_hit, w_miss_key, w_miss_timeout, w_is_normal;

  assign w_running    = bus.start && ((r_state == ST_WAIT) || (r_state == ST_ARMED) ||
                                      (r_state == ST_RESOLVED));
  assign w_start_rise = bus.start && !r_start_d;
  // a new mole is a fresh light or a jump to another position with no gap
  assign w_mole_start = bus.light_valid && (!r_lv_d || (bus.light_pos != r_pos));
  assign w_mole_end   = r_lv_d && !bus.light_valid;
  assign w_clr        = (r_state == ST_IDLE) && w_start_rise;
  assign w_is_normal  = (bus.mode == MODE_NORMAL) || (bus.mode == MODE_NORMAL_ALT);
  assign w_miss_cnt   = {1'b0, w_miss_key} + {1'b0, w_miss_timeout};
  assign w_moles_after = sat_add(w_moles, {1'b0, w_mole_start}, SAT_C);
  assign w_lives_after = (bus.mode != MODE_DEATH) ? r_lives :
                         (r_lives > w_miss_cnt) ? (r_lives - w_miss_cnt) : 2'd0;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // hit/miss decode: a key coinciding with a mole start belongs to the new
  // mole; an armed mole that ends or is replaced without a hit is a miss
  always_comb begin
    w_hit          = 1'b0;
    w_miss_key     = 1'b0;
    w_miss_timeout = 1'b0;
    if (w_running) begin
      if (bus.key_valid) begin
        if (w_mole_start) begin
          if (bus.key == bus.light_pos) begin
            w_hit = 1'b1;
          end else begin
            w_miss_key = 1'b1;
          end
        end else begin
          case (r_state)
            ST_ARMED: begin
              if (bus.key == r_pos) begin
                w_hit = 1'b1;
              end else begin
                w_miss_key = 1'b1;
              end
            end
            ST_WAIT: w_miss_key = 1'b1;
            default: w_hit = 1'b0;
          endcase
        end
      end else begin
        w_hit = 1'b0;
      end
      if ((r_state == ST_ARMED) && (w_mole_start || (w_mole_end && !w_hit))) begin
        w_miss_timeout = 1'b1;
      end else begin
        w_miss_timeout = 1'b0;
      end
    end else begin
      w_hit = 1'b0;
    end
  end

  // next state: mole tracking first, then the mode's end-of-game test
  always_comb begin
    w_scored     = r_state;
    w_state_next = r_state;
    if (w_mole_start) begin
      w_scored = w_hit ? ST_RESOLVED : ST_ARMED;
    end else if (r_state == ST_ARMED) begin
      w_scored = w_hit ? ST_RESOLVED : (w_mole_end ? ST_WAIT : ST_ARMED);
    end else if ((r_state == ST_RESOLVED) && w_mole_end) begin
      w_scored = ST_WAIT;
    end else begin
      w_scored = r_state;
    end
    case (r_state)
      ST_IDLE: w_state_next = w_start_rise ? ST_WAIT : ST_IDLE;
      ST_WAIT, ST_ARMED, ST_RESOLVED: begin
        if (!bus.start) begin
          w_state_next = ST_IDLE;
        end else if ((bus.mode == MODE_TIMED) && bus.time_up) begin
          w_state_next = ST_OVER;
        end else if ((bus.mode == MODE_DEATH) && (w_lives_after == 2'd0)) begin
          w_state_next = ST_OVER;
        end else if (w_is_normal && (w_moles_after == bus.max_hits) &&
                     (w_scored != ST_ARMED)) begin
          w_state_next = ST_OVER;
        end else begin
          w_state_next = w_scored;
        end
      end
      ST_OVER: w_state_next = bus.start ? ST_OVER : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // registered outputs, edge history, mole position and lives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_d    <= 1'b0;
      r_lv_d       <= 1'b0;
      r_pos        <= NO_POS;
      r_lives      <= LIVES_C;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_start_d    <= bus.start;
      r_lv_d       <= bus.light_valid;
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= (w_miss_cnt != 2'd0);
      r_game_over  <= (w_state_next == ST_OVER);
      if (w_running && w_mole_start) begin
        r_pos <= bus.light_pos;
      end
      if (w_clr) begin
        r_lives <= LIVES_C;
      end else if (w_running) begin
        r_lives <= w_lives_after;
      end
    end
  end

  sat_counter #(.SAT(SAT_C)) u_points (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_inc({1'b0, w_hit}), .o_count(w_points)
  );
  sat_counter #(.SAT(SAT_C)) u_misses (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_inc(w_miss_cnt), .o_count(w_misses)
  );
  sat_counter #(.SAT(SAT_C)) u_moles (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_inc({1'b0, w_running && w_mole_start}),
    .o_count(w_moles)
  );

  assign bus.points     = w_points;
  assign bus.misses     = w_misses;
  assign bus.moles      = w_moles;
  assign bus.lives_left = r_lives;
  assign bus.hit_pulse  = r_hit_pulse;
  assign bus.miss_pulse = r_miss_pulse;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: each scenario task drives the bus and
// compares outputs against hand-computed values one cycle after the edge.
module tb_hit_judge;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  hit_judge_if bus();

  hit_judge #(.LIVES(3), .SAT(99)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key       = k;
    tick(1);
    bus.key_valid = 1'b0;
  endtask

  task automatic new_game(input logic [1:0] m, input logic [6:0] mx);
    bus.start = 1'b0; bus.light_valid = 1'b0; bus.key_valid = 1'b0; bus.time_up = 1'b0;
    tick(1);
    bus.mode = m; bus.max_hits = mx; bus.start = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++; if (bus.points !== 7'd0) begin $display("FAIL reset.points got %0d exp 0", bus.points); n_fail++; end
    n_cmp++; if (bus.misses !== 7'd0) begin $display("FAIL reset.misses got %0d exp 0", bus.misses); n_fail++; end
    n_cmp++; if (bus.moles !== 7'd0) begin $display("FAIL reset.moles got %0d exp 0", bus.moles); n_fail++; end
    n_cmp++; if (bus.lives_left !== 2'd3) begin $display("FAIL reset.lives got %0d exp 3", bus.lives_left); n_fail++; end
    n_cmp++; if ({bus.hit_pulse, bus.miss_pulse, bus.game_over} !== 3'b000) begin
      $display("FAIL reset.flags got %b exp 000", {bus.hit_pulse, bus.miss_pulse, bus.game_over}); n_fail++; end
    reset = 1'b0;
  endtask

  task automatic test_normal_hit();
    new_game(2'd0, 7'd25);
    bus.light_valid = 1'b1; bus.light_pos = 4'd4;
    tick(1);
    n_cmp++; if (bus.moles !== 7'd1) begin $display("FAIL hit.moles got %0d exp 1", bus.moles); n_fail++; end
    tick(8);
    press(4'd4);
    n_cmp++; if (bus.points !== 7'd1) begin $display("FAIL hit.points got %0d exp 1", bus.points); n_fail++; end
    n_cmp++; if (bus.hit_pulse !== 1'b1) begin $display("FAIL hit.pulse got %b exp 1", bus.hit_pulse); n_fail++; end
    tick(1);
    n_cmp++; if (bus.hit_pulse !== 1'b0) begin $display("FAIL hit.pulse_drop got %b exp 0", bus.hit_pulse); n_fail++; end
    tick(8);
    press(4'd4);
    n_cmp++; if (bus.points !== 7'd1 || bus.hit_pulse !== 1'b0) begin
      $display("FAIL hit.double got points %0d pulse %b exp 1 0", bus.points, bus.hit_pulse); n_fail++; end
    bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.misses !== 7'd0) begin $display("FAIL hit.end_no_miss got %0d exp 0", bus.misses); n_fail++; end
  endtask

  task automatic test_timeout_wrong();
    new_game(2'd0, 7'd25);
    bus.light_valid = 1'b1; bus.light_pos = 4'd2;
    tick(3);
    bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.misses !== 7'd1 || bus.miss_pulse !== 1'b1) begin
      $display("FAIL timeout.miss got %0d pulse %b exp 1 1", bus.misses, bus.miss_pulse); n_fail++; end
    bus.light_valid = 1'b1; bus.light_pos = 4'd7;
    tick(1);
    press(4'd3);
    n_cmp++; if (bus.misses !== 7'd2 || bus.points !== 7'd0) begin
      $display("FAIL wrong_key got misses %0d points %0d exp 2 0", bus.misses, bus.points); n_fail++; end
    press(4'd7);
    n_cmp++; if (bus.points !== 7'd1 || bus.misses !== 7'd2) begin
      $display("FAIL wrong_then_right got points %0d misses %0d exp 1 2", bus.points, bus.misses); n_fail++; end
    bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.moles !== 7'd2 || bus.misses !== 7'd2) begin
      $display("FAIL timeout.tail got moles %0d misses %0d exp 2 2", bus.moles, bus.misses); n_fail++; end
  endtask

  task automatic test_deathmatch();
    logic [1:0] exp_l;
    new_game(2'd2, 7'd25);
    for (int i = 0; i < 3; i++) begin
      bus.light_valid = 1'b1; bus.light_pos = 4'd1;
      tick(2);
      bus.light_valid = 1'b0;
      tick(1);
      exp_l = 2'(2 - i);
      n_cmp++; if (bus.lives_left !== exp_l) begin
        $display("FAIL death.lives[%0d] got %0d exp %0d", i, bus.lives_left, exp_l); n_fail++; end
      n_cmp++; if (bus.game_over !== (i == 2)) begin
        $display("FAIL death.over[%0d] got %b exp %b", i, bus.game_over, (i == 2)); n_fail++; end
    end
    press(4'd5);
    n_cmp++; if (bus.misses !== 7'd3 || bus.miss_pulse !== 1'b0) begin
      $display("FAIL death.frozen got misses %0d pulse %b exp 3 0", bus.misses, bus.miss_pulse); n_fail++; end
    bus.light_valid = 1'b1; bus.light_pos = 4'd6;
    tick(1);
    n_cmp++; if (bus.moles !== 7'd3) begin $display("FAIL death.moles got %0d exp 3", bus.moles); n_fail++; end
  endtask

  task automatic test_normal_end();
    new_game(2'd0, 7'd2);
    bus.light_valid = 1'b1; bus.light_pos = 4'd0;
    tick(1);
    press(4'd0);
    bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.game_over !== 1'b0) begin $display("FAIL end.early got %b exp 0", bus.game_over); n_fail++; end
    bus.light_valid = 1'b1; bus.light_pos = 4'd8;
    tick(1);
    press(4'd8);
    n_cmp++; if (bus.game_over !== 1'b1 || bus.points !== 7'd2 || bus.hit_pulse !== 1'b1) begin
      $display("FAIL end.over got go %b points %0d pulse %b exp 1 2 1",
               bus.game_over, bus.points, bus.hit_pulse); n_fail++; end
    bus.light_valid = 1'b0;
    tick(1);
    bus.light_valid = 1'b1; bus.light_pos = 4'd3;
    tick(1);
    n_cmp++; if (bus.moles !== 7'd2 || bus.game_over !== 1'b1) begin
      $display("FAIL end.frozen got moles %0d go %b exp 2 1", bus.moles, bus.game_over); n_fail++; end
    bus.start = 1'b0; bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.game_over !== 1'b0 || bus.points !== 7'd2) begin
      $display("FAIL end.leave got go %b points %0d exp 0 2", bus.game_over, bus.points); n_fail++; end
  endtask

  task automatic test_same_cycle();
    new_game(2'd0, 7'd25);
    bus.light_valid = 1'b1; bus.light_pos = 4'd5;
    tick(1);
    bus.light_valid = 1'b0; bus.key_valid = 1'b1; bus.key = 4'd5;
    tick(1);
    bus.key_valid = 1'b0;
    n_cmp++; if (bus.points !== 7'd1 || bus.misses !== 7'd0) begin
      $display("FAIL same.key_end got points %0d misses %0d exp 1 0", bus.points, bus.misses); n_fail++; end
    bus.light_valid = 1'b1; bus.light_pos = 4'd6;
    tick(1);
    bus.light_pos = 4'd1;
    tick(1);
    n_cmp++; if (bus.misses !== 7'd1 || bus.moles !== 7'd3 || bus.miss_pulse !== 1'b1) begin
      $display("FAIL same.b2b got misses %0d moles %0d pulse %b exp 1 3 1",
               bus.misses, bus.moles, bus.miss_pulse); n_fail++; end
    bus.light_pos = 4'd2;
    press(4'd3);
    n_cmp++; if (bus.misses !== 7'd3 || bus.moles !== 7'd4 || bus.miss_pulse !== 1'b1) begin
      $display("FAIL same.double_miss got misses %0d moles %0d pulse %b exp 3 4 1",
               bus.misses, bus.moles, bus.miss_pulse); n_fail++; end
    tick(1);
    n_cmp++; if (bus.miss_pulse !== 1'b0) begin $display("FAIL same.pulse_single got %b exp 0", bus.miss_pulse); n_fail++; end
    bus.light_valid = 1'b0;
  endtask

  task automatic test_saturation_reset();
    logic [3:0] p;
    new_game(2'd1, 7'd25);
    for (int i = 0; i < 120; i++) begin
      p = 4'(i % 9);
      bus.light_valid = 1'b1; bus.light_pos = p;
      tick(1);
      press(p);
      bus.light_valid = 1'b0;
      tick(1);
    end
    n_cmp++; if (bus.points !== 7'd99 || bus.moles !== 7'd99) begin
      $display("FAIL sat.points got %0d moles %0d exp 99 99", bus.points, bus.moles); n_fail++; end
    n_cmp++; if (bus.game_over !== 1'b0) begin $display("FAIL sat.no_over got %b exp 0", bus.game_over); n_fail++; end
    bus.light_valid = 1'b1; bus.light_pos = 4'd4;
    tick(1);
    bus.key_valid = 1'b1; bus.key = 4'd4; reset = 1'b1;
    tick(1);
    n_cmp++; if (bus.points !== 7'd0 || bus.misses !== 7'd0 || bus.moles !== 7'd0 || bus.lives_left !== 2'd3) begin
      $display("FAIL rst_hit.counts got %0d %0d %0d %0d exp 0 0 0 3",
               bus.points, bus.misses, bus.moles, bus.lives_left); n_fail++; end
    n_cmp++; if ({bus.hit_pulse, bus.miss_pulse, bus.game_over} !== 3'b000) begin
      $display("FAIL rst_hit.flags got %b exp 000", {bus.hit_pulse, bus.miss_pulse, bus.game_over}); n_fail++; end
    reset = 1'b0; bus.key_valid = 1'b0; bus.light_valid = 1'b0;
    tick(1);
    n_cmp++; if (bus.hit_pulse !== 1'b0 || bus.points !== 7'd0) begin
      $display("FAIL rst_hit.after got pulse %b points %0d exp 0 0", bus.hit_pulse, bus.points); n_fail++; end
  endtask

  task automatic test_timed_end();
    new_game(2'd1, 7'd25);
    bus.light_valid = 1'b1; bus.light_pos = 4'd3;
    tick(1);
    bus.time_up = 1'b1; bus.key_valid = 1'b1; bus.key = 4'd3;
    tick(1);
    bus.key_valid = 1'b0; bus.time_up = 1'b0;
    n_cmp++; if (bus.game_over !== 1'b1 || bus.points !== 7'd1) begin
      $display("FAIL timed.over got go %b points %0d exp 1 1", bus.game_over, bus.points); n_fail++; end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0; bus.mode = 2'd0; bus.max_hits = 7'd25; bus.time_up = 1'b0;
    bus.light_valid = 1'b0; bus.light_pos = 4'd0; bus.key_valid = 1'b0; bus.key = 4'd0;
    test_reset();
    test_normal_hit();
    test_timeout_wrong();
    test_deathmatch();
    test_normal_end();
    test_same_cycle();
    test_saturation_reset();
    test_timed_end();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
